cube_alu_iter: RTL and testbench
================================

// Module: cube_alu_iter
// PURPOSE
// - Next-generation datapath ALU: DW-bit operands, valid/ready handshake, registered result and flags.
// - Dice-orientation rotation generalised to axis + quarter-turn count.
//   Applied iteratively, one quarter turn per clock.
// - Sits between decode and register writeback; the controller issues one op and waits for out_valid.
// PARAMETERS
// - DW       8  operand/result width (>= 4)
// - ORI_LSB  0  LSB position of the 3-bit orientation field in in0 (ORI_LSB+3 <= DW)
// PORTS
// - clk        in   1   clock, rising edge
// - rst_n      in   1   asynchronous active-low reset
// - in_valid   in   1   op request valid
// - in_ready   out  1   block can accept (high only in IDLE)
// - op         in   4   opcode (op_e)
// - axis       in   2   ROT axis: 0=RL 1=UD 2=FB 3=illegal
// - turns      in   2   ROT quarter turns (+90 deg each), 0..3
// - in0, in1   in   DW  operands
// - out_valid  out  1   result valid; held until out_ready
// - out_ready  in   1   consumer accepts result
// - out        out  DW  result
// - zf         out  1   zero/compare flag
// - err        out  1   illegal op/axis/orientation for the current result
// - busy       out  1   state != IDLE
// BEHAVIOUR
// - Reset (async, any state):
//   - state=IDLE; out, zf, err, out_valid, cf, turn counter all 0.
//   - An in-flight rotation is aborted; no result is produced.
// - FSM IDLE -> ROTATE -> HOLD -> IDLE. Accept on in_valid & in_ready; operands and op are latched.
// - Non-ROT ops: IDLE -> HOLD. out_valid rises 1 cycle after accept.
// - ROT, turns=n>0: ROTATE for n cycles, one quarter turn per cycle. HOLD follows; out_valid at accept+n+1.
// - ROT, turns=0: goes straight to HOLD with out=in0.
// - HOLD: out/zf/err/cf stable while out_valid=1. On out_ready -> IDLE. Max throughput: 1 op per 2 cycles.
// - Op results (widths DW, modulo 2^DW):
//   - NOP=0: out=0
//   - INC=1: in0+1, wraps
//   - DEC=2: in0-1, wraps
//   - CHECK=3: out=in0, zf=(in0==in1)
//   - PASS=4: out=in0 (LOAD/STORE/LI/MOV)
//   - ROT=5
//   - ADD=6: in0+in1, truncated
//   - SUB=7: |in0-in1|
// - zf=0 for every op except CHECK.
// - Ops 8..15: out=0, err=1, latency 1.
// - ROT keeps all bits outside the orientation field unchanged. Quarter-turn map, orientation codes 0..5:
//   - RL: 0->2->5->4->0; 1, 3 fixed
//   - UD: 0->1->5->3->0; 2, 4 fixed
//   - FB: 1->4->3->2->1; 0, 5 fixed
//   - 270 deg = turns 3.
// - ROT with axis=3, or orientation code 6/7: out=in0, err=1, no ROTATE cycles, latency 1.
// - in_valid while busy is ignored; the requester must hold it.
// - A new accept is possible in the cycle after the HOLD handshake.
// CONFIGURATION
// - CUBE_ALU_CARRY_EN defined: adds output port cf (1 bit, reset 0):
//   - INC/ADD: carry out
//   - DEC: in0==0
//   - SUB: in1>in0
//   - All other ops: 0
// - Undefined: no cf port and no carry logic; all other behaviour identical.
// STRUCTURE
// - Package cube_alu_pkg: op_e (4-bit opcodes above), axis_e (AX_RL/AX_UD/AX_FB), ORI_W=3,
//   state_e (IDLE/ROTATE/HOLD).
// - Sub-module cube_rot_step: combinational single +90 deg turn (axis, 3-bit ori -> ori, illegal flag).
//   Instantiated once on the working register.
// TESTING
// - Reset: release rst_n -> in_ready=1, out_valid=0, out=8'h00, zf=0, err=0.
// - ROT axis=0 turns=1 in0=8'hA8 -> out_valid 2 cycles after accept, out=8'hAA, err=0.
// - ROT axis=1 turns=3 in0=8'h01 -> 4 cycles, out=8'h00. Assert rst_n low mid-ROTATE -> no out_valid.
// - CHECK in0=in1=8'h3C, out_ready=0 for 3 cycles -> zf=1, out=8'h3C, held stable.
//   in_ready=0 until handshake.
// - DEC in0=8'h00 -> out=8'hFF; with CUBE_ALU_CARRY_EN, cf=1.
//   ADD 8'hF0+8'h20 -> out=8'h10, cf=1.
// - ROT in0=8'h0E (ori 6), and ROT axis=3 -> out=in0, err=1, latency 1.
//   op=4'hC -> out=0, err=1.

Source files
------------

// File: rtl/cube_alu_pkg.sv
// cube_alu_iter shared types: opcodes, rotation axes, FSM states.
// Orientation field is ORI_W bits wide; codes 0..5 are legal faces.
package cube_alu_pkg;

  localparam int ORI_W = 3;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_INC   = 4'd1,
    OP_DEC   = 4'd2,
    OP_CHECK = 4'd3,
    OP_PASS  = 4'd4,
    OP_ROT   = 4'd5,
    OP_ADD   = 4'd6,
    OP_SUB   = 4'd7
  } op_e;

  typedef enum logic [1:0] {
    AX_RL = 2'd0,
    AX_UD = 2'd1,
    AX_FB = 2'd2
  } axis_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROTATE = 2'd1,
    HOLD   = 2'd2
  } state_e;

endpackage

// File: rtl/cube_alu_iter_if.sv
// Request/response bundle for cube_alu_iter.
// CUBE_ALU_CARRY_EN adds the cf result flag.
interface cube_alu_iter_if #(
  parameter int DW = 8
);

  logic          in_valid;
  logic          in_ready;
  logic [3:0]    op;
  logic [1:0]    axis;
  logic [1:0]    turns;
  logic [DW-1:0] in0;
  logic [DW-1:0] in1;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out;
  logic          zf;
  logic          err;
  logic          busy;
`ifdef CUBE_ALU_CARRY_EN
  logic          cf;

  modport master (
    output in_valid, op, axis, turns,
    output in0, in1, out_ready,
    input  in_ready, out_valid, out,
    input  zf, err, busy, cf
  );

  modport slave (
    input  in_valid, op, axis, turns,
    input  in0, in1, out_ready,
    output in_ready, out_valid, out,
    output zf, err, busy, cf
  );
`else
  modport master (
    output in_valid, op, axis, turns,
    output in0, in1, out_ready,
    input  in_ready, out_valid, out,
    input  zf, err, busy
  );

  modport slave (
    input  in_valid, op, axis, turns,
    input  in0, in1, out_ready,
    output in_ready, out_valid, out,
    output zf, err, busy
  );
`endif

endinterface

// File: rtl/cube_rot_step.sv
// One +90 degree die turn about an axis.
// Illegal axis or face code passes ori through.
module cube_rot_step
  import cube_alu_pkg::*;
(
  input  logic [1:0]       axis,
  input  logic [ORI_W-1:0] ori,
  output logic [ORI_W-1:0] nori,
  output logic             illegal
);

  always_comb begin
    nori    = ori;
    illegal = (axis == 2'd3) || (ori > 3'd5);
    if (!illegal) begin
      unique case (1'b1)
        (axis == AX_RL): begin
          case (ori)
            3'd0:    nori = 3'd2;
            3'd2:    nori = 3'd5;
            3'd5:    nori = 3'd4;
            3'd4:    nori = 3'd0;
            default: nori = ori;
          endcase
        end
        (axis == AX_UD): begin
          case (ori)
            3'd0:    nori = 3'd1;
            3'd1:    nori = 3'd5;
            3'd5:    nori = 3'd3;
            3'd3:    nori = 3'd0;
            default: nori = ori;
          endcase
        end
        (axis == AX_FB): begin
          case (ori)
            3'd1:    nori = 3'd4;
            3'd4:    nori = 3'd3;
            3'd3:    nori = 3'd2;
            3'd2:    nori = 3'd1;
            default: nori = ori;
          endcase
        end
        default: nori = ori;
      endcase
    end
  end

endmodule

// File: rtl/cube_alu_iter.sv
// Iterative ALU with die-rotation op, one quarter turn per clock.
// Optional carry flag output under CUBE_ALU_CARRY_EN.
module cube_alu_iter
  import cube_alu_pkg::*;
#(
  parameter int DW      = 8,
  parameter int ORI_LSB = 0
) (
  input logic            clk,
  input logic            rst_n,
  cube_alu_iter_if.slave bus
);

  state_e           state;
  logic [DW-1:0]    work;
  logic [DW-1:0]    nxt;
  logic [DW-1:0]    res_q;
  logic [DW-1:0]    nres;
  logic [1:0]       cnt;
  logic [1:0]       ax;
  logic             zf_q;
  logic             err_q;
  logic             vld_q;
  logic             nzf;
  logic             nerr;
  logic             rot_bad;
  logic             step_bad;
  logic [ORI_W-1:0] step_ori;
`ifdef CUBE_ALU_CARRY_EN
  logic             cf_q;
  logic             ncf;
`endif

  assign rot_bad = (bus.axis == 2'd3) ||
                   (bus.in0[ORI_LSB +: ORI_W] > 3'd5);

  cube_rot_step u_step (
    .axis    (ax),
    .ori     (work[ORI_LSB +: ORI_W]),
    .nori    (step_ori),
    .illegal (step_bad)
  );

  always_comb begin
    nxt = work;
    nxt[ORI_LSB +: ORI_W] = step_ori;
  end

  always_comb begin
    nres = '0;
    nzf  = 1'b0;
    nerr = 1'b0;
`ifdef CUBE_ALU_CARRY_EN
    ncf  = 1'b0;
`endif
    case (bus.op)
      OP_NOP: nres = '0;
      OP_INC: begin
`ifdef CUBE_ALU_CARRY_EN
        {ncf, nres} = {1'b0, bus.in0} +
                      {{DW{1'b0}}, 1'b1};
`else
        nres = bus.in0 + DW'(1);
`endif
      end
      OP_DEC: begin
        nres = bus.in0 - DW'(1);
`ifdef CUBE_ALU_CARRY_EN
        ncf  = (bus.in0 == '0);
`endif
      end
      OP_CHECK: begin
        nres = bus.in0;
        nzf  = (bus.in0 == bus.in1);
      end
      OP_PASS: nres = bus.in0;
      // only reaches here for turns=0 or an illegal rotation
      OP_ROT: begin
        nres = bus.in0;
        nerr = rot_bad;
      end
      OP_ADD: begin
`ifdef CUBE_ALU_CARRY_EN
        {ncf, nres} = {1'b0, bus.in0} +
                      {1'b0, bus.in1};
`else
        nres = bus.in0 + bus.in1;
`endif
      end
      OP_SUB: begin
        if (bus.in0 >= bus.in1)
          nres = bus.in0 - bus.in1;
        else
          nres = bus.in1 - bus.in0;
`ifdef CUBE_ALU_CARRY_EN
        ncf = (bus.in1 > bus.in0);
`endif
      end
      default: nerr = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      work  <= '0;
      res_q <= '0;
      cnt   <= '0;
      ax    <= '0;
      zf_q  <= 1'b0;
      err_q <= 1'b0;
      vld_q <= 1'b0;
`ifdef CUBE_ALU_CARRY_EN
      cf_q  <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            if (bus.op == OP_ROT && !rot_bad &&
                bus.turns != 2'd0) begin
              state <= ROTATE;
              work  <= bus.in0;
              cnt   <= bus.turns;
              ax    <= bus.axis;
            end else begin
              state <= HOLD;
              res_q <= nres;
              zf_q  <= nzf;
              err_q <= nerr;
              vld_q <= 1'b1;
`ifdef CUBE_ALU_CARRY_EN
              cf_q  <= ncf;
`endif
            end
          end
        end
        ROTATE: begin
          work <= nxt;
          cnt  <= cnt - 2'd1;
          if (cnt == 2'd1) begin
            state <= HOLD;
            res_q <= nxt;
            zf_q  <= 1'b0;
            err_q <= step_bad;
            vld_q <= 1'b1;
`ifdef CUBE_ALU_CARRY_EN
            cf_q  <= 1'b0;
`endif
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state <= IDLE;
            vld_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = vld_q;
  assign bus.out       = res_q;
  assign bus.zf        = zf_q;
  assign bus.err       = err_q;
`ifdef CUBE_ALU_CARRY_EN
  assign bus.cf        = cf_q;
`endif

endmodule

// File: tb/tb_cube_alu_iter.sv
// Scoreboard bench for cube_alu_iter: driver queues expectations,
// monitor pops and compares on every rising out_valid.
module tb_cube_alu_iter;
  import cube_alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cube_alu_iter_if #(.DW(8)) bus ();

  cube_alu_iter #(.DW(8), .ORI_LSB(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [7:0] out;
    logic       zf;
    logic       err;
    logic       cf;
    int         lat;
    int         acc;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  logic pv = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (bus.out_valid) begin
      if (!pv) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_valid: got 1 want 0");
        end else begin
          cur = q.pop_front();
          chk("out", bus.out, cur.out);
          chk("zf", bus.zf, cur.zf);
          chk("err", bus.err, cur.err);
`ifdef CUBE_ALU_CARRY_EN
          chk("cf", bus.cf, cur.cf);
`endif
          chk("latency", cyc - cur.acc, cur.lat);
        end
      end else begin
        chk("hold_out", bus.out, cur.out);
        chk("hold_zf", bus.zf, cur.zf);
        chk("hold_err", bus.err, cur.err);
      end
    end
    pv = bus.out_valid;
  end

  task automatic issue(input logic [3:0] o,
                       input logic [1:0] a,
                       input logic [1:0] t,
                       input logic [7:0] x,
                       input logic [7:0] y,
                       input logic [7:0] eo,
                       input logic ez,
                       input logic ee,
                       input logic ec,
                       input int lat,
                       input int hold);
    exp_t e;
    @(negedge clk);
    chk("in_ready_idle", bus.in_ready, 1);
    bus.op = o;
    bus.axis = a;
    bus.turns = t;
    bus.in0 = x;
    bus.in1 = y;
    bus.in_valid = 1'b1;
    e.out = eo;
    e.zf = ez;
    e.err = ee;
    e.cf = ec;
    e.lat = lat;
    e.acc = cyc;
    q.push_back(e);
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 20 && !bus.out_valid; i++)
      @(negedge clk);
    if (!bus.out_valid) begin
      tests++;
      fails++;
      $display("FAIL timeout: got 0 want 1");
    end
    for (int i = 0; i < hold; i++) begin
      chk("in_ready_hold", bus.in_ready, 0);
      chk("busy_hold", bus.busy, 1);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.op = 4'd0;
    bus.axis = 2'd0;
    bus.turns = 2'd0;
    bus.in0 = 8'h00;
    bus.in1 = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out", bus.out, 8'h00);
    chk("rst_zf", bus.zf, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_busy", bus.busy, 0);
`ifdef CUBE_ALU_CARRY_EN
    chk("rst_cf", bus.cf, 0);
`endif

    issue(OP_ROT, 2'd0, 2'd1, 8'hA8, 8'h00,
          8'hAA, 0, 0, 0, 2, 0);
    issue(OP_ROT, 2'd1, 2'd3, 8'h01, 8'h00,
          8'h00, 0, 0, 0, 4, 0);
    issue(OP_CHECK, 2'd0, 2'd0, 8'h3C, 8'h3C,
          8'h3C, 1, 0, 0, 1, 3);
    issue(OP_CHECK, 2'd0, 2'd0, 8'h3C, 8'h3D,
          8'h3C, 0, 0, 0, 1, 0);
    issue(OP_DEC, 2'd0, 2'd0, 8'h00, 8'h00,
          8'hFF, 0, 0, 1, 1, 0);
    issue(OP_ADD, 2'd0, 2'd0, 8'hF0, 8'h20,
          8'h10, 0, 0, 1, 1, 0);
    issue(OP_ADD, 2'd0, 2'd0, 8'h7F, 8'h01,
          8'h80, 0, 0, 0, 1, 0);
    issue(OP_ROT, 2'd0, 2'd2, 8'h0E, 8'h00,
          8'h0E, 0, 1, 0, 1, 1);
    issue(OP_ROT, 2'd3, 2'd1, 8'h05, 8'h00,
          8'h05, 0, 1, 0, 1, 0);
    issue(4'hC, 2'd0, 2'd0, 8'h55, 8'h11,
          8'h00, 0, 1, 0, 1, 0);
    issue(OP_INC, 2'd0, 2'd0, 8'hFF, 8'h00,
          8'h00, 0, 0, 1, 1, 0);
    issue(OP_INC, 2'd0, 2'd0, 8'h41, 8'h00,
          8'h42, 0, 0, 0, 1, 0);
    issue(OP_SUB, 2'd0, 2'd0, 8'h10, 8'h30,
          8'h20, 0, 0, 1, 1, 0);
    issue(OP_SUB, 2'd0, 2'd0, 8'h30, 8'h10,
          8'h20, 0, 0, 0, 1, 0);
    issue(OP_NOP, 2'd0, 2'd0, 8'h55, 8'h66,
          8'h00, 0, 0, 0, 1, 0);
    issue(OP_PASS, 2'd0, 2'd0, 8'h5A, 8'h00,
          8'h5A, 0, 0, 0, 1, 0);
    issue(OP_ROT, 2'd2, 2'd2, 8'hF9, 8'h00,
          8'hFB, 0, 0, 0, 3, 0);
    issue(OP_ROT, 2'd0, 2'd0, 8'hC3, 8'h00,
          8'hC3, 0, 0, 0, 1, 0);
    issue(OP_ROT, 2'd0, 2'd3, 8'h20, 8'h00,
          8'h24, 0, 0, 0, 4, 2);

    // abort a rotation with reset; nothing is queued for it
    @(negedge clk);
    bus.op = OP_ROT;
    bus.axis = 2'd1;
    bus.turns = 2'd3;
    bus.in0 = 8'h01;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("busy_rotate", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_in_ready", bus.in_ready, 1);
    chk("abort_out_valid", bus.out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_no_valid", bus.out_valid, 0);
    end

    issue(OP_PASS, 2'd0, 2'd0, 8'h11, 8'h00,
          8'h11, 0, 0, 0, 1, 0);

    for (int i = 0; i < 20 && q.size() != 0; i++)
      @(negedge clk);
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: got %0d want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
